// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring decoder: FSM state encoding and the
// left-rotate step that the ring counter advances by each sample.
package ring_pkg;

    typedef enum logic {
        RING_HUNT   = 1'b0,
        RING_LOCKED = 1'b1
    } ring_state_t;

    localparam int unsigned RING_MAX_W = 64;

    // Rotate the low w bits of v left by one; bits above w come back zero.
    function automatic logic [RING_MAX_W-1:0] ring_rotate(input logic [RING_MAX_W-1:0] v,
                                                          input int unsigned w);
        logic [RING_MAX_W-1:0] mask;
        logic [RING_MAX_W-1:0] r;
        mask = (w >= RING_MAX_W) ? '1 : ((RING_MAX_W'(1) << w) - RING_MAX_W'(1));
        r    = ((v & mask) << 1) | ((v & mask) >> (w - 1));
        return r & mask;
    endfunction

endpackage

// File: rtl/ring_onehot_enc.sv
// Combinational one-hot checker and binary encoder for a ring sample.
module ring_onehot_enc #(
    parameter int WIDTH_REG = 8,
    parameter int IDX_W     = $clog2(WIDTH_REG)
) (
    input  logic [WIDTH_REG-1:0] vec_i,
    output logic                 is_onehot_o,
    output logic [IDX_W-1:0]     index_o
);

    always_comb begin
        is_onehot_o = (vec_i != '0) && ((vec_i & (vec_i - WIDTH_REG'(1))) == '0);
        index_o     = '0;
        for (int i = 0; i < WIDTH_REG; i++) begin
            if (vec_i[i]) index_o = IDX_W'(i);
        end
    end

endmodule

// File: rtl/ring_decoder.sv
// Ring-counter decoder: hunts for LOCK_CNT consecutive rotating one-hot samples,
// then tracks the sequence and flags errors. Error counter gated by RING_DECODER_ERR_CNT_EN.
module ring_decoder
    import ring_pkg::*;
#(
    parameter int WIDTH_REG = 8,
    parameter int LOCK_CNT  = 2,
    parameter int ERR_CNT_W = 8,
    parameter int IDX_W     = $clog2(WIDTH_REG)
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 in_valid,
    input  logic [WIDTH_REG-1:0] in_ring,
    output logic                 out_valid,
    output logic [IDX_W-1:0]     out_index,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    ring_state_t          state_q;
    logic [3:0]           hunt_cnt_q;
    logic [WIDTH_REG-1:0] expected_q;
    logic                 out_valid_q;
    logic [IDX_W-1:0]     out_index_q;
    logic                 err_pulse_q;

    logic                 is_onehot;
    logic [IDX_W-1:0]     idx;
    logic                 match;
    logic                 err_evt;
    logic [3:0]           hunt_cnt_d;
    logic [WIDTH_REG-1:0] ring_nxt;

    ring_onehot_enc #(.WIDTH_REG(WIDTH_REG), .IDX_W(IDX_W)) u_enc (
        .vec_i       (in_ring),
        .is_onehot_o (is_onehot),
        .index_o     (idx)
    );

    assign ring_nxt   = WIDTH_REG'(ring_rotate(RING_MAX_W'(in_ring), WIDTH_REG));
    assign match      = (in_ring == expected_q);
    assign hunt_cnt_d = match ? (hunt_cnt_q + 4'd1) : 4'd1;
    // Expected is always one-hot while locked, so a match implies a valid one-hot sample.
    assign err_evt    = in_valid && (state_q == RING_LOCKED) && !match;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= RING_HUNT;
            hunt_cnt_q  <= '0;
            expected_q  <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid && is_onehot;
            err_pulse_q <= err_evt;
            if (in_valid && is_onehot) out_index_q <= idx;
            if (in_valid) begin
                if (state_q == RING_LOCKED && match) begin
                    expected_q <= ring_nxt;
                end else if (!is_onehot) begin
                    state_q    <= RING_HUNT;
                    hunt_cnt_q <= '0;
                    expected_q <= '0;
                end else if (state_q == RING_LOCKED) begin
                    // Mismatching one-hot sample while locked reseeds the hunt.
                    state_q    <= RING_HUNT;
                    hunt_cnt_q <= 4'd1;
                    expected_q <= ring_nxt;
                end else begin
                    expected_q <= ring_nxt;
                    if (hunt_cnt_d >= 4'(LOCK_CNT)) begin
                        state_q    <= RING_LOCKED;
                        hunt_cnt_q <= '0;
                    end else begin
                        hunt_cnt_q <= hunt_cnt_d;
                    end
                end
            end
        end
    end

`ifdef RING_DECODER_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            err_cnt_q <= '0;
        end else if (err_evt && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign locked    = (state_q == RING_LOCKED);
    assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_ring_decoder.sv
// Directed self-checking bench for ring_decoder (WIDTH_REG=8, LOCK_CNT=2, ERR_CNT_W=8);
// error-count expectations follow RING_DECODER_ERR_CNT_EN.
module tb_ring_decoder;

`ifdef RING_DECODER_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_ring = '0;
    logic       out_valid;
    logic [2:0] out_index;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_cnt;

    int passed = 0;
    int total  = 0;

    ring_decoder #(.WIDTH_REG(8), .LOCK_CNT(2), .ERR_CNT_W(8)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_valid  (in_valid),
        .in_ring   (in_ring),
        .out_valid (out_valid),
        .out_index (out_index),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rotl(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

    function automatic logic [7:0] exp_err(input int n);
        return ERR_EN ? 8'(n) : 8'd0;
    endfunction

    task automatic sample(input logic [7:0] r);
        @(negedge clk);
        in_valid = 1'b1;
        in_ring  = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_ring  = 8'hA5;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if ({out_valid, out_index, locked, err_pulse, err_cnt} !== 14'd0)
            $display("FAIL reset_outputs: got %h want 0", {out_valid, out_index, locked, err_pulse, err_cnt}); else passed++;
    endtask

    task automatic test_lock();
        sample(8'h01);
        total++; if (out_valid !== 1'b1 || out_index !== 3'd0 || locked !== 1'b0)
            $display("FAIL lock_s1: vld=%b idx=%0d lock=%b want 1 0 0", out_valid, out_index, locked); else passed++;
        sample(8'h02);
        total++; if (out_index !== 3'd1 || locked !== 1'b1)
            $display("FAIL lock_s2: idx=%0d lock=%b want 1 1", out_index, locked); else passed++;
        sample(8'h04);
        total++; if (out_index !== 3'd2 || locked !== 1'b1 || err_cnt !== 8'd0 || err_pulse !== 1'b0)
            $display("FAIL lock_s3: idx=%0d lock=%b err=%0d pulse=%b want 2 1 0 0", out_index, locked, err_cnt, err_pulse); else passed++;
    endtask

    task automatic test_wrap();
        logic [7:0] seq [6] = '{8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        logic [2:0] idx [6] = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        for (int i = 0; i < 6; i++) begin
            sample(seq[i]);
            if (i >= 3) begin
                total++; if (out_index !== idx[i] || locked !== 1'b1 || err_pulse !== 1'b0 || out_valid !== 1'b1)
                    $display("FAIL wrap_%0d: idx=%0d lock=%b pulse=%b want %0d 1 0", i, out_index, locked, err_pulse, idx[i]); else passed++;
            end
        end
    endtask

    task automatic test_error();
        do_reset();
        sample(8'h01);
        sample(8'h02);
        sample(8'h08);
        total++; if (err_pulse !== 1'b1 || locked !== 1'b0 || err_cnt !== exp_err(1) || out_index !== 3'd3)
            $display("FAIL err_hit: pulse=%b lock=%b cnt=%0d idx=%0d want 1 0 %0d 3", err_pulse, locked, err_cnt, out_index, exp_err(1)); else passed++;
        sample(8'h10);
        total++; if (err_pulse !== 1'b0 || locked !== 1'b1 || err_cnt !== exp_err(1))
            $display("FAIL err_relock: pulse=%b lock=%b cnt=%0d want 0 1 %0d", err_pulse, locked, err_cnt, exp_err(1)); else passed++;
    endtask

    task automatic test_multihot_gap();
        do_reset();
        sample(8'h01);
        sample(8'h02);
        sample(8'h03);
        total++; if (out_valid !== 1'b0 || err_pulse !== 1'b1 || locked !== 1'b0 || out_index !== 3'd1)
            $display("FAIL multihot: vld=%b pulse=%b lock=%b idx=%0d want 0 1 0 1", out_valid, err_pulse, locked, out_index); else passed++;
        sample(8'h04);
        total++; if (locked !== 1'b0 || err_pulse !== 1'b0 || out_index !== 3'd2)
            $display("FAIL reseed: lock=%b pulse=%b idx=%0d want 0 0 2", locked, err_pulse, out_index); else passed++;
        idle(5);
        total++; if (out_valid !== 1'b0 || err_pulse !== 1'b0 || locked !== 1'b0 || out_index !== 3'd2)
            $display("FAIL gap_hunt: vld=%b pulse=%b lock=%b idx=%0d want 0 0 0 2", out_valid, err_pulse, locked, out_index); else passed++;
        sample(8'h08);
        total++; if (locked !== 1'b1 || out_index !== 3'd3 || err_cnt !== exp_err(1))
            $display("FAIL gap_lock: lock=%b idx=%0d cnt=%0d want 1 3 %0d", locked, out_index, err_cnt, exp_err(1)); else passed++;
        idle(5);
        total++; if (out_valid !== 1'b0 || locked !== 1'b1 || out_index !== 3'd3 || err_pulse !== 1'b0)
            $display("FAIL gap_locked: vld=%b lock=%b idx=%0d pulse=%b want 0 1 3 0", out_valid, locked, out_index, err_pulse); else passed++;
        sample(8'h10);
        total++; if (locked !== 1'b1 || err_pulse !== 1'b0 || out_index !== 3'd4 || err_cnt !== exp_err(1))
            $display("FAIL gap_resume: lock=%b pulse=%b idx=%0d cnt=%0d want 1 0 4 %0d", locked, err_pulse, out_index, err_cnt, exp_err(1)); else passed++;
    endtask

    task automatic test_saturation();
        logic [7:0] cur;
        do_reset();
        cur = 8'h01;
        sample(cur);
        for (int i = 0; i < 300; i++) begin
            cur = rotl(cur);
            sample(cur);
            if (i == 0) begin
                total++; if (locked !== 1'b1)
                    $display("FAIL sat_lock0: lock=%b want 1", locked); else passed++;
            end
            cur = rotl(rotl(cur));
            sample(cur);
            if (i == 0 || i == 254 || i == 299) begin
                total++; if (err_cnt !== exp_err((i >= 254) ? 255 : i + 1) || err_pulse !== 1'b1 || locked !== 1'b0)
                    $display("FAIL sat_%0d: cnt=%0d pulse=%b lock=%b want %0d 1 0", i, err_cnt, err_pulse, locked, exp_err((i >= 254) ? 255 : i + 1)); else passed++;
            end
        end
        idle(2);
        total++; if (err_cnt !== exp_err(255) || err_pulse !== 1'b0)
            $display("FAIL sat_hold: cnt=%0d pulse=%b want %0d 0", err_cnt, err_pulse, exp_err(255)); else passed++;
    endtask

    task automatic test_reset_locked();
        do_reset();
        sample(8'h01);
        sample(8'h02);
        sample(8'h10);
        @(negedge clk);
        n_rst    = 1'b0;
        in_valid = 1'b1;
        in_ring  = 8'h20;
        @(posedge clk);
        #1;
        total++; if ({out_valid, out_index, locked, err_pulse, err_cnt} !== 14'd0)
            $display("FAIL rst_locked: got %h want 0", {out_valid, out_index, locked, err_pulse, err_cnt}); else passed++;
        @(negedge clk);
        n_rst = 1'b1;
        in_valid = 1'b0;
        sample(8'h20);
        total++; if (out_index !== 3'd5 || locked !== 1'b0 || out_valid !== 1'b1)
            $display("FAIL relock_s1: idx=%0d lock=%b vld=%b want 5 0 1", out_index, locked, out_valid); else passed++;
        sample(8'h40);
        total++; if (out_index !== 3'd6 || locked !== 1'b1 || err_cnt !== 8'd0)
            $display("FAIL relock_s2: idx=%0d lock=%b cnt=%0d want 6 1 0", out_index, locked, err_cnt); else passed++;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_wrap();
        test_error();
        test_multihot_gap();
        test_saturation();
        test_reset_locked();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
